// File: rtl/bombe_rotor_stepper.sv
// Sequencing controller for a 3-rotor bombe search: steps fast/mid/slow rotor
// positions as an odometer, settles each position, samples match, stops on hit or exhaustion.
module bombe_rotor_stepper #(
   parameter int unsigned NUM_POS = 26,
   parameter int unsigned SETTLE  = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       load,
   input  logic [4:0] init_fast,
   input  logic [4:0] init_mid,
   input  logic [4:0] init_slow,
   input  logic       start,
   input  logic       match,
   input  logic       resume,
   input  logic       abort,
   output logic [4:0] pos_fast,
   output logic [4:0] pos_mid,
   output logic [4:0] pos_slow,
   output logic       step_pulse,
   output logic       busy,
   output logic       found,
   output logic       done,
   output logic [2:0] current_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'b000,
      S_CHECK = 3'b001,
      S_STEP  = 3'b010,
      S_HIT   = 3'b011,
      S_DONE  = 3'b100
   } state_e;

   localparam logic [4:0]  POS_MAX     = 5'(NUM_POS - 1);
   localparam logic [5:0]  POS_LIMIT   = 6'(NUM_POS);
   localparam logic [14:0] LAST_STEP   = 15'(NUM_POS * NUM_POS * NUM_POS - 1);
   localparam logic [3:0]  SETTLE_INIT = 4'(SETTLE);

   state_e      state_q, state_d;
   logic [4:0]  fast_q, fast_d;
   logic [4:0]  mid_q, mid_d;
   logic [4:0]  slow_q, slow_d;
   logic [3:0]  settle_q, settle_d;
   logic [14:0] step_cnt_q, step_cnt_d;
   logic        pulse_q, pulse_d;
   logic        busy_q, busy_d;
   logic        found_q, found_d;
   logic        done_q, done_d;
   logic        advance;

   function automatic logic [4:0] clip_init(input logic [4:0] v);
      return ({1'b0, v} >= POS_LIMIT) ? '0 : v;
   endfunction

   function automatic logic [4:0] wrap_inc(input logic [4:0] v);
      return (v == POS_MAX) ? '0 : v + 5'd1;
   endfunction

   always_comb begin
      state_d    = state_q;
      fast_d     = fast_q;
      mid_d      = mid_q;
      slow_d     = slow_q;
      settle_d   = settle_q;
      step_cnt_d = step_cnt_q;
      advance    = 1'b0;

      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (load) begin
                  fast_d = clip_init(init_fast);
                  mid_d  = clip_init(init_mid);
                  slow_d = clip_init(init_slow);
               end else if (start) begin
                  step_cnt_d = '0;
                  settle_d   = SETTLE_INIT;
                  state_d    = S_CHECK;
               end
            end
            S_CHECK: begin
               if (settle_q != '0) begin
                  settle_d = settle_q - 4'd1;
               end else if (match) begin
                  state_d = S_HIT;
               end else if (step_cnt_q == LAST_STEP) begin
                  state_d = S_DONE;
               end else begin
                  advance = 1'b1;
               end
            end
            S_STEP: begin
               settle_d = SETTLE_INIT;
               state_d  = S_CHECK;
            end
            S_HIT: begin
               if (resume) advance = 1'b1;
            end
            S_DONE: begin
               if (start) begin
                  step_cnt_d = '0;
                  settle_d   = SETTLE_INIT;
                  state_d    = S_CHECK;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      // Positions change on the edge into STEP, so step_pulse and the new position appear together.
      if (advance) begin
         fast_d = wrap_inc(fast_q);
         if (fast_q == POS_MAX) begin
            mid_d = wrap_inc(mid_q);
            if (mid_q == POS_MAX) slow_d = wrap_inc(slow_q);
         end
         if (step_cnt_q != LAST_STEP) step_cnt_d = step_cnt_q + 15'd1;
         state_d = S_STEP;
      end

      pulse_d = advance;
      busy_d  = (state_d == S_CHECK) || (state_d == S_STEP) || (state_d == S_HIT);
      found_d = (state_d == S_HIT);
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         fast_q     <= '0;
         mid_q      <= '0;
         slow_q     <= '0;
         settle_q   <= '0;
         step_cnt_q <= '0;
         pulse_q    <= 1'b0;
         busy_q     <= 1'b0;
         found_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         fast_q     <= fast_d;
         mid_q      <= mid_d;
         slow_q     <= slow_d;
         settle_q   <= settle_d;
         step_cnt_q <= step_cnt_d;
         pulse_q    <= pulse_d;
         busy_q     <= busy_d;
         found_q    <= found_d;
         done_q     <= done_d;
      end
   end

   assign pos_fast      = fast_q;
   assign pos_mid       = mid_q;
   assign pos_slow      = slow_q;
   assign step_pulse    = pulse_q;
   assign busy          = busy_q;
   assign found         = found_q;
   assign done          = done_q;
   assign current_state = state_q;

endmodule

// File: tb/tb_bombe_rotor_stepper.sv
// Bench for bombe_rotor_stepper: two instances (SETTLE=2 and SETTLE=0) share stimulus and are
// compared every cycle against a linear-index odometer model, plus directed constant checks.
module tb_bombe_rotor_stepper;

   localparam int TOTAL    = 17576;
   localparam int ST_IDLE  = 0;
   localparam int ST_CHECK = 1;
   localparam int ST_STEP  = 2;
   localparam int ST_HIT   = 3;
   localparam int ST_DONE  = 4;

   logic       clk = 1'b0;
   logic       resetn, load, start, match, resume, abort;
   logic [4:0] init_fast, init_mid, init_slow;
   logic [4:0] pf[2], pm[2], ps[2];
   logic       sp[2], bs[2], fd[2], dn[2];
   logic [2:0] cs[2];

   always #5 clk = ~clk;

   bombe_rotor_stepper #(.NUM_POS(26), .SETTLE(2)) dut_s2 (
      .clk(clk), .resetn(resetn), .load(load),
      .init_fast(init_fast), .init_mid(init_mid), .init_slow(init_slow),
      .start(start), .match(match), .resume(resume), .abort(abort),
      .pos_fast(pf[0]), .pos_mid(pm[0]), .pos_slow(ps[0]),
      .step_pulse(sp[0]), .busy(bs[0]), .found(fd[0]), .done(dn[0]),
      .current_state(cs[0])
   );

   bombe_rotor_stepper #(.NUM_POS(26), .SETTLE(0)) dut_s0 (
      .clk(clk), .resetn(resetn), .load(load),
      .init_fast(init_fast), .init_mid(init_mid), .init_slow(init_slow),
      .start(start), .match(match), .resume(resume), .abort(abort),
      .pos_fast(pf[1]), .pos_mid(pm[1]), .pos_slow(ps[1]),
      .step_pulse(sp[1]), .busy(bs[1]), .found(fd[1]), .done(dn[1]),
      .current_state(cs[1])
   );

   // Model: position is a single index fast + 26*mid + 676*slow; stepping is index+1 mod 26^3.
   int m_st[2], m_idx[2], m_settle[2], m_steps[2];
   bit m_pulse[2];
   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   function automatic int settle_of(input int i);
      return (i == 0) ? 2 : 0;
   endfunction

   function automatic int sanit(input logic [4:0] v);
      return (v >= 5'd26) ? 0 : int'(v);
   endfunction

   task automatic model_reset(input int i);
      m_st[i] = ST_IDLE; m_idx[i] = 0; m_settle[i] = 0; m_steps[i] = 0; m_pulse[i] = 0;
   endtask

   task automatic model_advance(input int i);
      m_idx[i]   = (m_idx[i] + 1) % TOTAL;
      m_steps[i] = (m_steps[i] < TOTAL - 1) ? m_steps[i] + 1 : m_steps[i];
      m_pulse[i] = 1;
      m_st[i]    = ST_STEP;
   endtask

   task automatic model_clock(input int i);
      m_pulse[i] = 0;
      if (abort) begin
         m_st[i] = ST_IDLE;
      end else begin
         case (m_st[i])
            ST_IDLE:
               if (load) m_idx[i] = sanit(init_fast) + 26 * sanit(init_mid) + 676 * sanit(init_slow);
               else if (start) begin m_steps[i] = 0; m_settle[i] = settle_of(i); m_st[i] = ST_CHECK; end
            ST_CHECK:
               if (m_settle[i] > 0) m_settle[i]--;
               else if (match) m_st[i] = ST_HIT;
               else if (m_steps[i] == TOTAL - 1) m_st[i] = ST_DONE;
               else model_advance(i);
            ST_STEP: begin m_settle[i] = settle_of(i); m_st[i] = ST_CHECK; end
            ST_HIT:  if (resume) model_advance(i);
            default: if (start) begin m_steps[i] = 0; m_settle[i] = settle_of(i); m_st[i] = ST_CHECK; end
         endcase
      end
   endtask

   function automatic logic [31:0] model_vec(input int i);
      int f, m, s;
      bit b;
      f = m_idx[i] % 26;
      m = (m_idx[i] / 26) % 26;
      s = m_idx[i] / 676;
      b = (m_st[i] >= ST_CHECK) && (m_st[i] <= ST_HIT);
      return {10'd0, 3'(m_st[i]), b, m_st[i] == ST_HIT, m_st[i] == ST_DONE, m_pulse[i],
              5'(s), 5'(m), 5'(f)};
   endfunction

   function automatic logic [31:0] dut_vec(input int i);
      return {10'd0, cs[i], bs[i], fd[i], dn[i], sp[i], ps[i], pm[i], pf[i]};
   endfunction

   function automatic logic [31:0] pos_of(input int i);
      return {17'd0, ps[i], pm[i], pf[i]};
   endfunction

   function automatic logic [31:0] P(input int f, input int m, input int s);
      return {17'd0, 5'(s), 5'(m), 5'(f)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (!resetn) model_reset(i);
         else model_clock(i);
      end
      #1;
      for (int i = 0; i < 2; i++) check($sformatf("cycle_settle%0d", settle_of(i)), dut_vec(i), model_vec(i));
   endtask

   task automatic set_init(input int f, input int m, input int s);
      init_fast = 5'(f); init_mid = 5'(m); init_slow = 5'(s);
   endtask

   initial begin
      int cycles, pulses;
      resetn = 1'b0; load = 1'b0; start = 1'b0; match = 1'b0; resume = 1'b0; abort = 1'b0;
      set_init(0, 0, 0);
      model_reset(0); model_reset(1);

      // reset held, then asserted again in the middle of a search
      repeat (3) tick();
      resetn = 1'b1;
      tick();
      load = 1'b1; set_init(5, 6, 7); tick();
      load = 1'b0; start = 1'b1; tick();
      start = 1'b0;
      repeat (6) tick();
      resetn = 1'b0;
      #2;
      check("async_reset", dut_vec(0), 32'd0);
      model_reset(0); model_reset(1);
      repeat (2) tick();
      resetn = 1'b1;
      tick();
      check("reset_idle_s2", dut_vec(0), 32'd0);
      check("reset_idle_s0", dut_vec(1), 32'd0);

      // 25/25/3: three CHECK cycles then a single step to 0/0/4
      load = 1'b1; set_init(25, 25, 3); tick();
      load = 1'b0; start = 1'b1; tick();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("t2_check_dwell", 32'(cs[0]), 32'(ST_CHECK));
         check("t2_no_pulse", 32'(sp[0]), 32'd0);
         tick();
      end
      check("t2_pulse", 32'(sp[0]), 32'd1);
      check("t2_pos", pos_of(0), P(0, 0, 4));
      tick();
      check("t2_pulse_single", 32'(sp[0]), 32'd0);

      // 25/25/25 wraps to 0/0/0
      abort = 1'b1; tick();
      abort = 1'b0; load = 1'b1; set_init(25, 25, 25); tick();
      load = 1'b0; start = 1'b1; tick();
      start = 1'b0;
      repeat (4) tick();
      check("t3_pos_wrap", pos_of(0), P(0, 0, 0));
      check("t3_step_cnt", 32'(dut_s2.step_cnt_q), 32'd1);

      // hit on the second check, hold, resume
      abort = 1'b1; tick();
      abort = 1'b0; load = 1'b1; set_init(0, 0, 0); tick();
      load = 1'b0; start = 1'b1; tick();
      start = 1'b0;
      repeat (4) tick();
      check("t4_second_pos", pos_of(0), P(1, 0, 0));
      match = 1'b1;
      repeat (3) tick();
      check("t4_hit_state", 32'(cs[0]), 32'(ST_HIT));
      check("t4_found", 32'(fd[0]), 32'd1);
      match = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         check("t4_frozen", pos_of(0), P(1, 0, 0));
         check("t4_found_hold", 32'(fd[0]), 32'd1);
      end
      resume = 1'b1; tick();
      resume = 1'b0;
      check("t4_resume_pulse", 32'(sp[0]), 32'd1);
      check("t4_resume_pos", pos_of(0), P(2, 0, 0));
      tick();
      check("t4_resume_check", 32'(cs[0]), 32'(ST_CHECK));

      // full exhaustion on the SETTLE=0 instance
      abort = 1'b1; tick();
      abort = 1'b0; load = 1'b1; set_init(0, 0, 0); tick();
      load = 1'b0; match = 1'b0; start = 1'b1; tick();
      start = 1'b0;
      cycles = 0; pulses = 0;
      while (!dn[1] && cycles < 40000) begin
         tick();
         cycles++;
         if (sp[1]) pulses++;
      end
      check("t5_cycles_to_done", 32'(cycles), 32'd35151);
      check("t5_pulse_count", 32'(pulses), 32'd17575);
      check("t5_done_pos", pos_of(1), P(25, 25, 25));
      check("t5_done_flag", 32'(dn[1]), 32'd1);
      check("t5_not_busy", 32'(bs[1]), 32'd0);
      load = 1'b1; start = 1'b1; set_init(3, 4, 5); tick();
      load = 1'b0; start = 1'b0;
      check("t5_load_ignored", pos_of(1), P(25, 25, 25));
      check("t5_restart", 32'(cs[1]), 32'(ST_CHECK));
      check("t5_restart_cnt", 32'(dut_s0.step_cnt_q), 32'd0);

      // abort during CHECK, then out-of-range load
      abort = 1'b1; tick();
      abort = 1'b0; load = 1'b1; set_init(7, 3, 1); tick();
      load = 1'b0; start = 1'b1; tick();
      start = 1'b0;
      tick();
      abort = 1'b1; tick();
      abort = 1'b0;
      check("t6_abort_idle", 32'(cs[0]), 32'(ST_IDLE));
      check("t6_abort_pos", pos_of(0), P(7, 3, 1));
      check("t6_abort_busy", 32'(bs[0]), 32'd0);
      load = 1'b1; set_init(30, 2, 26); tick();
      load = 1'b0;
      check("t6_clip_load", pos_of(0), P(0, 2, 0));

      // randomized traffic
      for (int k = 0; k < 4000; k++) begin
         load   = ($urandom_range(7) == 0);
         start  = ($urandom_range(5) == 0);
         match  = ($urandom_range(3) == 0);
         resume = ($urandom_range(4) == 0);
         abort  = ($urandom_range(49) == 0);
         set_init($urandom_range(31), $urandom_range(31), $urandom_range(31));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
